fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the 9-bit core. It replaces the fixed PC / instruction-ROM pairing with four capabilities: a decoupled prefetch queue, a valid/ready handshake toward decode, redirect with flush for taken branches, and a halt/drain sequence with a cycle counter. It sits between the synchronous instruction ROM and the control decoder. Branch targets arrive already resolved (e.g. from the branch LUT) on `RedirTarget`.

---
 rtl/fetch_queue_if.sv | 21 ++
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Decode-side handshake of the fetch front end.
// Fetch is master (presents head), decode is slave (accepts).
interface fetch_queue_if #(
  parameter int P = 12,
  parameter int W = 9
);
  logic [W-1:0] InstOut;
  logic [P-1:0] InstPC;
  logic         InstValid;
  logic         InstReady;

  modport master (
    output InstOut, InstPC, InstValid,
    input  InstReady
  );

  modport slave (
    input  InstOut, InstPC, InstValid,
    output InstReady
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: prefetch queue, redirect flush,
// halt/drain sequencing and a saturating cycle counter.
module fetch_queue #(
  parameter int P = 12,
  parameter int W = 9,
  parameter int DEPTH = 4,
  parameter logic [P-1:0] RESET_PC = '0
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  output logic [P-1:0]             ImemAddr,
  output logic                     ImemRe,
  input  logic [W-1:0]             ImemData,
  fetch_queue_if.master            dec,
  input  logic                     Redirect,
  input  logic [P-1:0]             RedirTarget,
  input  logic                     Halt,
  output logic                     Halted,
  output logic [15:0]              CycleCt,
  output logic [$clog2(DEPTH):0]   QCount
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [P-1:0]  fpc_q, fpc_d;
  logic [P-1:0]  ifpc_q, ifpc_d;
  logic          ifv_q, ifv_d;
  logic          kill_q, kill_d;
  logic          halt_q, halt_d;
  logic          halted_q, halted_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   cyc_q, cyc_d;

  logic [P-1:0]  pc_mem  [DEPTH];
  logic [W-1:0]  ins_mem [DEPTH];

  logic          push, pop, full;
  logic [CW:0]   used;

  // Credits: queued entries plus the one response still in flight.
  assign used     = {1'b0, cnt_q} + (CW+1)'(ifv_q);
  assign ImemRe   = Reset_n && !halt_q && !Halt &&
                    (Redirect || used < DEPTH_W);
  assign ImemAddr = Redirect ? RedirTarget : fpc_q;

  assign pop  = vld_q && dec.InstReady;
  assign push = ifv_q && !kill_q && !Redirect;
  assign full = cnt_q == CW'(DEPTH);

  always_comb begin
    fpc_d    = ImemRe ? ImemAddr + P'(1) : fpc_q;
    ifv_d    = ImemRe;
    ifpc_d   = ImemRe ? ImemAddr : ifpc_q;
    kill_d   = Redirect && !ImemRe;
    halt_d   = halt_q || Halt;
    halted_d = halted_q ||
               (halt_q && cnt_q == '0 && !ifv_q);
    cyc_d    = cyc_q;
    if (!halted_q && cyc_q != 16'hFFFF)
      cyc_d = cyc_q + 16'd1;
    rd_d  = rd_q + AW'(pop);
    wr_d  = wr_q + AW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (Redirect) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
    vld_d = cnt_d != '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fpc_q    <= RESET_PC;
      ifpc_q   <= RESET_PC;
      ifv_q    <= 1'b0;
      kill_q   <= 1'b0;
      halt_q   <= 1'b0;
      halted_q <= 1'b0;
      vld_q    <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      cyc_q    <= '0;
    end else begin
      fpc_q    <= fpc_d;
      ifpc_q   <= ifpc_d;
      ifv_q    <= ifv_d;
      kill_q   <= kill_d;
      halt_q   <= halt_d;
      halted_q <= halted_d;
      vld_q    <= vld_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      pc_mem[wr_q]  <= ifpc_q;
      ins_mem[wr_q] <= ImemData;
    end
  end

  assign dec.InstOut   = ins_mem[rd_q];
  assign dec.InstPC    = pc_mem[rd_q];
  assign dec.InstValid = vld_q;
  assign QCount        = cnt_q;
  assign Halted        = halted_q;
  assign CycleCt       = cyc_q;

  a_no_push_full: assert property (
    @(posedge Clk) disable iff (!Reset_n)
    !(push && full)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: ordered PC stream model,
// random ready/redirect, halt drain and async reset scenarios.
module tb_fetch_queue;
  localparam int P = 12;
  localparam int W = 9;
  localparam int DEPTH = 4;
  localparam logic [P-1:0] RPC = 12'hFFE;

  typedef struct packed {
    logic [P-1:0] pc;
    logic [W-1:0] ins;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [P-1:0] imem_addr;
  logic         imem_re;
  logic [W-1:0] imem_data = '0;
  logic         redir = 1'b0;
  logic [P-1:0] redir_tgt = '0;
  logic         halt = 1'b0;
  logic         halted;
  logic [15:0]  cycle_ct;
  logic [$clog2(DEPTH):0] qcount;

  fetch_queue_if #(.P(P), .W(W)) dec ();

  fetch_queue #(
    .P(P), .W(W), .DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .ImemAddr(imem_addr),
    .ImemRe(imem_re),
    .ImemData(imem_data),
    .dec(dec),
    .Redirect(redir),
    .RedirTarget(redir_tgt),
    .Halt(halt),
    .Halted(halted),
    .CycleCt(cycle_ct),
    .QCount(qcount)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] romf(input logic [P-1:0] a);
    logic [W-1:0] t;
    t = a[W-1:0] ^ 9'h15A;
    return t ^ {6'd0, a[P-1:P-3]};
  endfunction

  always @(posedge clk)
    if (imem_re) imem_data <= romf(imem_addr);

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit stream_open = 1'b0;
  bit halt_phase = 1'b0;
  logic [P-1:0] next_pc = '0;
  ent_t exp_q[$];
  ent_t e;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", n, a, x, cyc);
    end
  endtask

  // Monitor: pops the expected stream on every transfer.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (!halt_phase)
        chk("cycle_ct", {16'd0, cycle_ct}, cyc);
      if (dec.InstValid && dec.InstReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer got pc=%h exp=none cyc=%0d",
                   dec.InstPC, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_pc", {20'd0, dec.InstPC}, {20'd0, e.pc});
          chk("xfer_ins", {23'd0, dec.InstOut}, {23'd0, e.ins});
        end
      end
      if (redir) begin
        exp_q.delete();
        if (stream_open) next_pc = redir_tgt;
      end
      while (stream_open && exp_q.size() < 16) begin
        exp_q.push_back('{next_pc, romf(next_pc)});
        next_pc = next_pc + 12'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_cyc(input int k);
    while (cyc < k) step();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen3;
    dec.InstReady = 1'b0;
    #23;
    chk("rst_re", {31'd0, imem_re}, 0);
    chk("rst_addr", {20'd0, imem_addr}, {20'd0, RPC});
    chk("rst_valid", {31'd0, dec.InstValid}, 0);
    chk("rst_qcount", {29'd0, qcount}, 0);
    chk("rst_cyclect", {16'd0, cycle_ct}, 0);
    chk("rst_halted", {31'd0, halted}, 0);

    stream_open = 1'b1;
    next_pc = RPC;
    dec.InstReady = 1'b1;
    release_rst();
    #1;
    chk("c0_re", {31'd0, imem_re}, 1);
    chk("c0_addr", {20'd0, imem_addr}, {20'd0, RPC});
    to_cyc(1);
    chk("c1_valid", {31'd0, dec.InstValid}, 0);
    to_cyc(2);
    chk("c2_valid", {31'd0, dec.InstValid}, 1);
    chk("c2_pc", {20'd0, dec.InstPC}, {20'd0, RPC});

    to_cyc(7);
    chk("c7_pc", {20'd0, dec.InstPC}, 32'h003);
    redir = 1'b1;
    redir_tgt = 12'h100;
    #1;
    chk("redir_addr", {20'd0, imem_addr}, 32'h100);
    chk("redir_re", {31'd0, imem_re}, 1);
    step();
    redir = 1'b0;
    chk("bubble_q", {29'd0, qcount}, 0);
    chk("bubble_v", {31'd0, dec.InstValid}, 0);
    step();
    chk("tgt_valid", {31'd0, dec.InstValid}, 1);
    chk("tgt_pc", {20'd0, dec.InstPC}, 32'h100);

    to_cyc(12);
    dec.InstReady = 1'b0;
    to_cyc(21);
    #1;
    chk("full_q", {29'd0, qcount}, DEPTH);
    chk("full_re", {31'd0, imem_re}, 0);
    step();
    dec.InstReady = 1'b1;

    for (int i = 0; i < 400; i++) begin
      step();
      dec.InstReady = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 19) == 0);
      redir_tgt = P'($urandom);
    end
    step();
    redir = 1'b0;
    dec.InstReady = 1'b0;

    step();
    redir = 1'b1;
    redir_tgt = 12'h7F0;
    step();
    redir = 1'b0;
    seen3 = 1'b0;
    for (int i = 0; i < 20 && !seen3; i++) begin
      step();
      if (qcount == 3) seen3 = 1'b1;
    end
    chk("fill_to_3", {31'd0, seen3}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, dec.InstValid}, 0);
    chk("arst_qcount", {29'd0, qcount}, 0);
    chk("arst_cyclect", {16'd0, cycle_ct}, 0);
    chk("arst_halted", {31'd0, halted}, 0);
    chk("arst_re", {31'd0, imem_re}, 0);

    mon_en = 1'b0;
    exp_q.delete();
    stream_open = 1'b0;
    halt_phase = 1'b1;
    for (int i = 0; i < 5; i++)
      exp_q.push_back('{RPC + P'(i), romf(RPC + P'(i))});
    dec.InstReady = 1'b1;
    repeat (3) @(posedge clk);
    release_rst();

    to_cyc(2);
    chk("h_c2_valid", {31'd0, dec.InstValid}, 1);
    chk("h_c2_pc", {20'd0, dec.InstPC}, {20'd0, RPC});
    to_cyc(5);
    halt = 1'b1;
    #1;
    chk("halt_re", {31'd0, imem_re}, 0);
    step();
    halt = 1'b0;
    chk("h_c6_pc", {20'd0, dec.InstPC}, 32'h002);
    to_cyc(7);
    chk("h_c7_valid", {31'd0, dec.InstValid}, 0);
    chk("h_c7_halted", {31'd0, halted}, 0);
    to_cyc(8);
    chk("h_c8_halted", {31'd0, halted}, 1);
    chk("h_c8_cyc", {16'd0, cycle_ct}, 8);
    to_cyc(10);
    redir = 1'b1;
    redir_tgt = 12'h200;
    #1;
    chk("h_redir_re", {31'd0, imem_re}, 0);
    step();
    redir = 1'b0;
    to_cyc(15);
    chk("h_c15_cyc", {16'd0, cycle_ct}, 8);
    chk("h_c15_halted", {31'd0, halted}, 1);
    chk("h_c15_valid", {31'd0, dec.InstValid}, 0);
    chk("h_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
